pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
- Instruction-fetch front end: owns the PC register and issues in-order requests to instruction memory.
- Buffers returned instructions for decode.
- Consumes the 2-bit jump_sel produced by the execute-stage branch decision ({b_jal, jalr}) together with its targets, redirects the PC, and discards stale in-flight fetches.
- Sits between the EX-stage branch decision and the IF/ID boundary.

Parameters:
XLEN, 64, PC/address width
RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
DEPTH, 2, maximum of outstanding requests plus buffered instructions (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX stage holds a valid instruction; qualifies jump_sel
jump_sel  in  2  {b_jal, jalr} from branch decision
branch_target  in  XLEN  PC+imm target, used when jump_sel[1]
jalr_target  in  XLEN  rs1+imm target, used when jump_sel[0]
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_rsp_valid  in  1  response valid; in order; one per accepted request; never back-pressured
imem_rsp_data  in  32  instruction word
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts
if_pc  out  XLEN  PC of presented instruction
if_inst  out  32  presented instruction
flush  out  1  redirect taken this cycle; kills younger IF/ID/ID-EX contents
trap_misalign  out  1  one-cycle pulse: redirect target not 4-byte aligned

Behaviour:
- Reset (async assert, sync deassert):
  - pc=RESET_PC, state=BOOT, FIFO empty, outstanding=0, drop_cnt=0.
  - All outputs 0 except imem_req_addr=RESET_PC.
- States:
  - BOOT: one idle cycle after reset release, then RUN.
  - RUN: normal fetch.
  - No other states.
- Redirect request: ex_valid & (jump_sel!=0).
  - Target = jalr_target with bit0 cleared when jump_sel[0] (jalr has priority if 2'b11).
  - Otherwise target = branch_target.
  - If target[1]=1: trap_misalign=1 that cycle; no redirect, no flush; fetch continues.
  - Else redirect taken, same cycle, combinational:
    - flush=1.
    - imem_req_valid forced 0.
    - FIFO cleared next edge.
    - drop_cnt <= outstanding minus any response arriving this cycle.
    - pc <= target.
- Request issue:
  - imem_req_valid = RUN & !redirect & (outstanding + fifo_count < DEPTH).
  - imem_req_addr = pc.
  - On valid&ready: pc <= pc+4 (wraps modulo 2^XLEN), outstanding+1.
- Response:
  - Decrements outstanding.
  - If drop_cnt>0: decrement drop_cnt, discard data.
  - Else push {pc_of_request, data} into FIFO.
  - Request PCs are held in a DEPTH-entry tag queue, pushed on request handshake and popped on response.
  - A response in a redirect cycle is dropped (accounted in drop_cnt).
- Decode handshake:
  - if_valid = FIFO non-empty; if_pc/if_inst = FIFO head.
  - Pop on if_valid&if_ready.
  - Outputs stable while if_valid&!if_ready.
  - if_valid=0 in the cycle after a redirect.
- Simultaneous events: FIFO push and pop in the same cycle keeps count; request and response in the same cycle keep outstanding.
- Invariant: outstanding + fifo_count <= DEPTH at all times, so FIFO never overflows.
- Latency: redirect at cycle N -> request to target at N+1 (if ready) -> if_valid earliest one cycle after the response.
- Reset mid-operation: everything returns to reset values immediately. Memory is reset on the same rst_n, so no responses are expected afterwards.

Decomposition:
- Shared package: XLEN, RESET_PC, jump_sel bit positions (JS_BJAL=1, JS_JALR=0), instruction width 32.
- One natural sub-module: sync_fifo (parameterised width/depth).
  - Instantiated twice: instruction buffer {pc,inst} and request-PC tag queue.
- Counters and FSM stay in pc_fetch.

Test Plan:
- Reset, release, imem_req_ready=1, 1-cycle memory: first request at cycle 2 with addr 0x80000000; then 0x80000004, 0x80000008; decode sees matching if_pc/if_inst in order.
- if_ready=0 with DEPTH=2: exactly 2 requests issued, imem_req_valid stays 0, if_pc=0x80000000 held stable; raising if_ready resumes fetch at 0x80000008.
- Two requests outstanding (0x80000010, 0x80000014), redirect with jump_sel=2'b10, branch_target=0x80000100:
  - flush=1 that cycle; both responses dropped.
  - Next request addr 0x80000100; first if_pc=0x80000100.
- jump_sel=2'b01, jalr_target=0x80000201: redirect to 0x80000200. jump_sel=2'b11: jalr_target wins.
- branch_target=0x80000102 with ex_valid=1: trap_misalign pulses one cycle, flush=0, sequential fetch continues; same input with ex_valid=0: no effect.
- Redirect in the same cycle a response arrives with a FIFO pop pending: the response is discarded, the FIFO is empty next cycle, and outstanding/drop_cnt reach 0 once stale responses drain.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package pc_fetch_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam int ILEN = 32;

    // Bit positions inside jump_sel = {b_jal, jalr}
    localparam int JS_BJAL = 1;
    localparam int JS_JALR = 0;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_if.sv
// Bundle of branch-decision, instruction-memory and decode signals around pc_fetch.
interface pc_fetch_if #(
    parameter int XLEN = pc_fetch_pkg::XLEN
);
    import pc_fetch_pkg::*;

    logic            ex_valid;
    logic [1:0]      jump_sel;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jalr_target;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;

    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_inst;

    logic            flush;
    logic            trap_misalign;

    // master = fetch unit, slave = surrounding pipeline / memory
    modport master (
        input  ex_valid, jump_sel, branch_target, jalr_target,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst,
        output flush, trap_misalign
    );

    modport slave (
        output ex_valid, jump_sel, branch_target, jalr_target,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst,
        input  flush, trap_misalign
    );

endinterface

// File: rtl/pc_fetch_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through head and a synchronous clear.
module pc_fetch_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    // Clear wins over any push/pop in the same cycle
    assign w_push = i_push & ~i_clr;
    assign w_pop  = i_pop & ~i_clr & (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: PC register, in-order imem requests, decode buffer
// and branch/jump redirect with discard of stale in-flight fetches.
module pc_fetch #(
    parameter int              XLEN     = pc_fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = pc_fetch_pkg::RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_fetch_if.master bus
);
    import pc_fetch_pkg::*;

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] LSB_CLR = ~{{(XLEN-1){1'b0}}, 1'b1};

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_drop_cnt;

    logic            w_redirect_req;
    logic [XLEN-1:0] w_target;
    logic            w_redirect;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp_keep;
    logic            w_if_pop;
    logic [CW:0]     w_occupancy;
    logic [CW-1:0]   w_outstanding;
    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_empty;
    logic [XLEN-1:0] w_tag_pc;
    logic [XLEN+ILEN-1:0] w_fifo_dout;

    // Gated by rst_n so flush/trap stay low while reset is held
    assign w_redirect_req = rst_n & bus.ex_valid & (bus.jump_sel != 2'b00);
    assign w_target       = bus.jump_sel[JS_JALR] ? (bus.jalr_target & LSB_CLR)
                                                  : bus.branch_target;
    assign w_redirect     = w_redirect_req & ~w_target[1];

    assign w_occupancy = {1'b0, w_outstanding} + {1'b0, w_fifo_count};
    assign w_req_valid = (r_state == ST_RUN) & ~w_redirect & (w_occupancy < DEPTH_LIM);
    assign w_req_fire  = w_req_valid & bus.imem_req_ready;

    assign w_rsp_keep   = bus.imem_rsp_valid & ~w_redirect & (r_drop_cnt == '0);
    assign w_fifo_empty = (w_fifo_count == '0);
    assign w_if_pop     = ~w_fifo_empty & bus.if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase

            if (w_redirect)      r_pc <= w_target;
            else if (w_req_fire) r_pc <= r_pc + XLEN'(4);

            // Everything still in flight at a redirect is stale, except a response landing now
            if (w_redirect)
                r_drop_cnt <= w_outstanding - CW'(bus.imem_rsp_valid);
            else if (bus.imem_rsp_valid && (r_drop_cnt != '0))
                r_drop_cnt <= r_drop_cnt - CW'(1);
        end
    end

    // Tag queue occupancy is exactly the number of outstanding requests
    pc_fetch_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (1'b0),
        .i_push  (w_req_fire),
        .i_din   (r_pc),
        .i_pop   (bus.imem_rsp_valid),
        .o_dout  (w_tag_pc),
        .o_count (w_outstanding)
    );

    pc_fetch_sync_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_redirect),
        .i_push  (w_rsp_keep),
        .i_din   ({w_tag_pc, bus.imem_rsp_data}),
        .i_pop   (w_if_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.flush          = w_redirect;
    assign bus.trap_misalign  = w_redirect_req & w_target[1];
    assign bus.if_valid       = ~w_fifo_empty;
    assign bus.if_pc          = w_fifo_empty ? '0 : w_fifo_dout[ILEN +: XLEN];
    assign bus.if_inst        = w_fifo_empty ? '0 : w_fifo_dout[ILEN-1:0];

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: redirect vector table plus hand-written streaming,
// back-pressure, flush and reset sequences against a small in-order memory model.
module tb_pc_fetch;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_if #(.XLEN(64)) bus ();

    pc_fetch #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        ev;
        logic [1:0]  js;
        logic [63:0] bt;
        logic [63:0] jt;
        logic        exp_flush;
        logic        exp_trap;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t vecs[10];

    // Memory model: in order, one response per accepted request, one cycle later
    logic        mem_hold = 1'b0;
    logic        m_fire;
    logic [63:0] m_addr;
    logic [63:0] pending[$];

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_BEEF;
    endfunction

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            m_fire = rst_n && bus.imem_req_valid && bus.imem_req_ready;
            m_addr = bus.imem_req_addr;
            @(posedge clk);
            #2;
            if (m_fire) pending.push_back(m_addr);
            if (!rst_n) pending.delete();
            if (!mem_hold && pending.size() > 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = inst_of(pending.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        bus.ex_valid      = 1'b0;
        bus.jump_sel      = 2'b00;
        bus.branch_target = '0;
        bus.jalr_target   = '0;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        clear_ex();
        #1;
    endtask

    // Leaves the bench at the negedge of the first RUN cycle
    task automatic release_reset();
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot_idle_req_valid", 64'(bus.imem_req_valid), 64'd0);
        step();
        @(negedge clk);
        chk("run_req_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("run_req_addr", bus.imem_req_addr, 64'h8000_0000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          got;
        int          n_fire;
        logic [63:0] exp_pc;
        logic [63:0] fire_addr;
        logic        seen_fire;

        vecs[0] = '{1'b0, 2'b10, 64'h8000_0100, 64'h0,         1'b0, 1'b0, 64'h8000_0000};
        vecs[1] = '{1'b1, 2'b00, 64'h8000_0100, 64'h8000_0200, 1'b0, 1'b0, 64'h8000_0000};
        vecs[2] = '{1'b1, 2'b10, 64'h8000_0100, 64'h0,         1'b1, 1'b0, 64'h8000_0100};
        vecs[3] = '{1'b1, 2'b01, 64'h8000_0300, 64'h8000_0201, 1'b1, 1'b0, 64'h8000_0200};
        vecs[4] = '{1'b1, 2'b11, 64'h8000_0400, 64'h8000_0500, 1'b1, 1'b0, 64'h8000_0500};
        vecs[5] = '{1'b1, 2'b10, 64'h8000_0102, 64'h0,         1'b0, 1'b1, 64'h8000_0500};
        vecs[6] = '{1'b0, 2'b10, 64'h8000_0102, 64'h0,         1'b0, 1'b0, 64'h8000_0500};
        vecs[7] = '{1'b1, 2'b01, 64'h8000_0100, 64'h8000_0603, 1'b0, 1'b1, 64'h8000_0500};
        vecs[8] = '{1'b1, 2'b11, 64'h8000_0102, 64'h8000_0700, 1'b1, 1'b0, 64'h8000_0700};
        vecs[9] = '{1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC};

        clear_ex();
        bus.imem_req_ready = 1'b0;
        bus.if_ready       = 1'b0;
        #1;
        rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_req_addr", bus.imem_req_addr, 64'h8000_0000);
        chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
        chk("rst_if_pc", bus.if_pc, 64'd0);
        chk("rst_if_inst", 64'(bus.if_inst), 64'd0);
        chk("rst_flush", 64'(bus.flush), 64'd0);
        chk("rst_trap", 64'(bus.trap_misalign), 64'd0);
        release_reset();

        // Redirect table, memory never ready so the PC only moves on redirect
        for (int i = 0; i < 10; i++) begin
            step();
            bus.ex_valid      = vecs[i].ev;
            bus.jump_sel      = vecs[i].js;
            bus.branch_target = vecs[i].bt;
            bus.jalr_target   = vecs[i].jt;
            @(negedge clk);
            $display("[TB] vec %0d ev=%0b js=%b flush=%0b trap=%0b", i, vecs[i].ev, vecs[i].js,
                     bus.flush, bus.trap_misalign);
            chk($sformatf("vec%0d_flush", i), 64'(bus.flush), 64'(vecs[i].exp_flush));
            chk($sformatf("vec%0d_trap", i), 64'(bus.trap_misalign), 64'(vecs[i].exp_trap));
            chk($sformatf("vec%0d_req_valid", i), 64'(bus.imem_req_valid), 64'(!vecs[i].exp_flush));
            step();
            clear_ex();
            @(negedge clk);
            chk($sformatf("vec%0d_pc", i), bus.imem_req_addr, vecs[i].exp_pc);
            chk($sformatf("vec%0d_if_valid", i), 64'(bus.if_valid), 64'd0);
        end

        // PC wrap at the top of the address space
        step();
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        chk("wrap_req_addr", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        chk("wrap_pc", bus.imem_req_addr, 64'd0);
        chk("wrap_if_valid_early", 64'(bus.if_valid), 64'd0);
        step();
        @(negedge clk);
        $display("[TB] wrap fetch if_valid=%0b pc=%h", bus.if_valid, bus.if_pc);
        chk("wrap_if_valid", 64'(bus.if_valid), 64'd1);
        chk("wrap_if_pc", bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_if_inst", 64'(bus.if_inst), 64'(inst_of(64'hFFFF_FFFF_FFFF_FFFC)));

        // Asynchronous reset with a buffered instruction
        step();
        assert_reset();
        chk("async_rst_if_valid", 64'(bus.if_valid), 64'd0);
        chk("async_rst_addr", bus.imem_req_addr, 64'h8000_0000);
        chk("async_rst_req_valid", 64'(bus.imem_req_valid), 64'd0);

        // Streaming with a 1-cycle memory
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        release_reset();
        exp_pc = 64'h8000_0000;
        got    = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            step();
            @(negedge clk);
            if (bus.if_valid) begin
                $display("[TB] stream pc=%h inst=%h", bus.if_pc, bus.if_inst);
                chk("stream_pc", bus.if_pc, exp_pc);
                chk("stream_inst", 64'(bus.if_inst), 64'(inst_of(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                got++;
            end
        end
        chk("stream_count", 64'(got), 64'd3);

        // Decode back-pressure: exactly DEPTH requests, head held stable
        step();
        assert_reset();
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b0;
        release_reset();
        n_fire = (bus.imem_req_valid && bus.imem_req_ready) ? 1 : 0;
        for (int c = 0; c < 8; c++) begin
            step();
            @(negedge clk);
            if (bus.imem_req_valid && bus.imem_req_ready) n_fire++;
            if (bus.if_valid) chk("hold_if_pc", bus.if_pc, 64'h8000_0000);
        end
        $display("[TB] backpressure fires=%0d", n_fire);
        chk("hold_fire_count", 64'(n_fire), 64'd2);
        chk("hold_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("hold_if_inst", 64'(bus.if_inst), 64'(inst_of(64'h8000_0000)));
        step();
        bus.if_ready = 1'b1;
        seen_fire = 1'b0;
        fire_addr = '0;
        for (int c = 0; c < 10 && !seen_fire; c++) begin
            @(negedge clk);
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                seen_fire = 1'b1;
                fire_addr = bus.imem_req_addr;
            end
            step();
        end
        chk("resume_fire_seen", 64'(seen_fire), 64'd1);
        chk("resume_addr", fire_addr, 64'h8000_0008);

        // Redirect with two requests outstanding; both responses dropped
        assert_reset();
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        mem_hold           = 1'b1;
        release_reset();
        repeat (2) begin
            step();
            @(negedge clk);
        end
        chk("two_out_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("two_out_count", 64'(dut.w_outstanding), 64'd2);
        step();
        bus.ex_valid      = 1'b1;
        bus.jump_sel      = 2'b10;
        bus.branch_target = 64'h8000_0100;
        @(negedge clk);
        chk("flush_out_flush", 64'(bus.flush), 64'd1);
        chk("flush_out_req_valid", 64'(bus.imem_req_valid), 64'd0);
        step();
        clear_ex();
        mem_hold = 1'b0;
        @(negedge clk);
        chk("flush_out_if_valid", 64'(bus.if_valid), 64'd0);
        chk("flush_out_pc", bus.imem_req_addr, 64'h8000_0100);
        seen_fire = 1'b0;
        fire_addr = '0;
        got       = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            step();
            @(negedge clk);
            if (!seen_fire && bus.imem_req_valid && bus.imem_req_ready) begin
                seen_fire = 1'b1;
                fire_addr = bus.imem_req_addr;
            end
            if (bus.if_valid) begin
                $display("[TB] after flush pc=%h inst=%h", bus.if_pc, bus.if_inst);
                chk("flush_first_pc", bus.if_pc, 64'h8000_0100);
                chk("flush_first_inst", 64'(bus.if_inst), 64'(inst_of(64'h8000_0100)));
                got = 1;
            end
        end
        chk("flush_first_fire", fire_addr, 64'h8000_0100);
        chk("flush_if_seen", 64'(got), 64'd1);
        chk("flush_drop_cnt", 64'(dut.r_drop_cnt), 64'd0);

        // Redirect while a response arrives and the head is being popped
        step();
        assert_reset();
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        release_reset();
        step();
        step();
        bus.ex_valid    = 1'b1;
        bus.jump_sel    = 2'b01;
        bus.jalr_target = 64'h8000_0801;
        @(negedge clk);
        chk("race_if_valid", 64'(bus.if_valid), 64'd1);
        chk("race_rsp_valid", 64'(bus.imem_rsp_valid), 64'd1);
        chk("race_flush", 64'(bus.flush), 64'd1);
        step();
        clear_ex();
        @(negedge clk);
        chk("race_fifo_empty", 64'(bus.if_valid), 64'd0);
        chk("race_outstanding", 64'(dut.w_outstanding), 64'd0);
        chk("race_drop_cnt", 64'(dut.r_drop_cnt), 64'd0);
        chk("race_pc", bus.imem_req_addr, 64'h8000_0800);
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            step();
            @(negedge clk);
            if (bus.if_valid) begin
                $display("[TB] after race pc=%h inst=%h", bus.if_pc, bus.if_inst);
                chk("race_first_pc", bus.if_pc, 64'h8000_0800);
                got = 1;
            end
        end
        chk("race_if_seen", 64'(got), 64'd1);
        step();
        bus.imem_req_ready = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("drain_outstanding", 64'(dut.w_outstanding), 64'd0);
        chk("drain_drop_cnt", 64'(dut.r_drop_cnt), 64'd0);
        chk("drain_if_valid", 64'(bus.if_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
